// File: rtl/uart_word_rx.sv
// uart_word_rx: 8N1 UART receiver that packs four consecutive bytes, first byte
// in [7:0], into a 32-bit word. The word leaves through a valid/ready handshake.
// The receiver samples at mid-bit, rejects glitches and times out between bytes.
// Error flags are sticky.
// Optional feature macro: UART_WORD_RX_PARITY_EN selects 8E1 framing with a parity check.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rx,
  output logic [31:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [3:0]  error_flags,
  input  logic        error_clr
);

  localparam int CW = $clog2(CLKS_PER_BIT * TIMEOUT_BITS + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] TO_LIM  = CW'(CLKS_PER_BIT * TIMEOUT_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state, state_nx;
  logic          rx_meta, rx_sync;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [1:0]    byte_idx;
  logic [31:0]   word_buf;

  logic cnt_clr, cnt_inc, shift, par_chk, stop_smp, timeout;
  logic par_bad, par_err, byte_ok, frame_err, word_done, load, overrun;

  // Two-flop synchroniser; the line idles high, so reset to 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state and per-cycle control strobes. The shared counter also times out idle gaps.
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    shift    = 1'b0;
    par_chk  = 1'b0;
    stop_smp = 1'b0;
    timeout  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_sync) begin
          state_nx = S_START;
          cnt_clr  = 1'b1;
        end else if (byte_idx != 2'd0) begin
          if (cnt == TO_LIM) begin
            timeout = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_clr  = 1'b1;
          state_nx = rx_sync ? S_IDLE : S_DATA;
        end else cnt_inc = 1'b1;
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr = 1'b1;
          shift   = 1'b1;
`ifdef UART_WORD_RX_PARITY_EN
          if (bit_idx == 3'd7) state_nx = S_PARITY;
`else
          if (bit_idx == 3'd7) state_nx = S_STOP;
`endif
        end else cnt_inc = 1'b1;
      end
`ifdef UART_WORD_RX_PARITY_EN
      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          par_chk  = 1'b1;
          state_nx = S_STOP;
        end else cnt_inc = 1'b1;
      end
`endif
      S_STOP: begin
        // Return to IDLE at mid-stop, so a start bit right after the stop bit is caught.
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          stop_smp = 1'b1;
          state_nx = S_IDLE;
        end else cnt_inc = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef UART_WORD_RX_PARITY_EN
  assign par_err = par_chk & (rx_sync != ^shreg);

  // Remember a parity mismatch until this frame's stop bit is judged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     par_bad <= 1'b0;
    else if (par_chk) par_bad <= par_err;
  end
`else
  assign par_err = 1'b0;
  assign par_bad = 1'b0;
`endif

  assign byte_ok   = stop_smp & rx_sync & ~par_bad;
  assign frame_err = stop_smp & ~rx_sync;
  assign word_done = byte_ok & (byte_idx == 2'd3);
  assign load      = word_done & (~data_valid | data_ready);
  assign overrun   = word_done & data_valid & ~data_ready;

  // Bit counter, bit shifter and word assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      bit_idx  <= 3'd0;
      shreg    <= 8'd0;
      byte_idx <= 2'd0;
      word_buf <= 32'd0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (shift) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (timeout || frame_err || par_err) byte_idx <= 2'd0;
      else if (byte_ok)                    byte_idx <= byte_idx + 2'd1;
      if (byte_ok) word_buf[byte_idx*8 +: 8] <= shreg;
    end
  end

  // Output holding register with a valid/ready handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out   <= 32'd0;
      data_valid <= 1'b0;
    end else if (load) begin
      data_out   <= {shreg, word_buf[23:0]};
      data_valid <= 1'b1;
    end else if (data_ready) begin
      data_valid <= 1'b0;
    end
  end

  // Sticky error flags. A new error wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) error_flags <= 4'd0;
    else error_flags <= (error_clr ? 4'd0 : error_flags) |
                        {timeout, par_err, overrun, frame_err};
  end

endmodule

// File: tb/tb_uart_word_rx.sv
// Testbench for uart_word_rx. Expected words come from a byte-level model and go into
// a queue. A monitor compares each word as the DUT hands it over.
module tb_uart_word_rx;
  localparam int CPB = 16;
  localparam int TOB = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        data_ready = 1'b1;
  logic        error_clr = 1'b0;
  logic [31:0] data_out;
  logic        data_valid;
  logic [3:0]  error_flags;

  uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .reset_n(reset_n), .uart_rx(uart_rx), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .error_flags(error_flags),
    .error_clr(error_clr)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  part[$];
  logic [3:0]  mflags = 4'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model at the byte level. A good byte joins the partial word. Any error
  // drops the partial word. A complete word is queued, unless an unconsumed word is
  // already held while the consumer stalls.
  task automatic model_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
    logic [31:0] w;
    if (!par_ok)  begin mflags[2] = 1'b1; part.delete(); end
    if (!stop_ok) begin mflags[0] = 1'b1; part.delete(); end
    if (stop_ok && par_ok) begin
      part.push_back(b);
      if (part.size() == 4) begin
        w = {part[3], part[2], part[1], part[0]};
        part.delete();
        if (exp_q.size() != 0 && !data_ready) mflags[1] = 1'b1;
        else exp_q.push_back(w);
      end
    end
  endtask

  task automatic model_timeout();
    if (part.size() != 0) mflags[3] = 1'b1;
    part.delete();
  endtask

  task automatic idle(input int bits);
    uart_rx = 1'b1;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit par_flip);
    logic [10:0] fr;
    int nb;
    model_byte(b, stop_bit, !par_flip);
`ifdef UART_WORD_RX_PARITY_EN
    fr = {stop_bit, (^b) ^ par_flip, b, 1'b0};
    nb = 11;
`else
    fr = {1'b0, stop_bit, b, 1'b0};
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      uart_rx = fr[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1, 1'b0);
    idle(gap);
  endtask

  task automatic check_flags(input string nm);
    chk(nm, {28'd0, error_flags}, {28'd0, mflags});
  endtask

  task automatic clear_flags();
    @(negedge clk) error_clr = 1'b1;
    @(negedge clk) error_clr = 1'b0;
    mflags = 4'd0;
    check_flags("flags_after_clr");
  endtask

  // The monitor takes a word on any cycle where the handshake completes.
  always @(negedge clk) begin
    if (reset_n && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h expected none", data_out);
      end else begin
        chk("word", data_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_flags", {28'd0, error_flags}, 32'd0);
    reset_n = 1'b1;
    idle(2);

    // Back-to-back bytes form one word.
    send_word(32'hDEADBEEF, 2);
    check_flags("t1_flags");

    // A bad stop bit drops the partial word.
    send_byte(8'hAA, 1'b1, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    idle(1);
    send_word(32'h11223344, 2);
    check_flags("t2_flags");
    clear_flags();

    // Consumer stalls, so the second word overruns.
    data_ready = 1'b0;
    send_word(32'h01020304, 1);
    send_word(32'hA5A5A5A5, 1);
    chk("t3_valid", {31'd0, data_valid}, 32'd1);
    chk("t3_held", data_out, 32'h01020304);
    check_flags("t3_flags");
    @(posedge clk); #1 data_ready = 1'b1;
    idle(1);
    chk("t3_valid_drop", {31'd0, data_valid}, 32'd0);
    clear_flags();

    // A short low pulse is a glitch, not a byte.
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3);
    check_flags("t4_flags");

    // An idle gap between bytes of one word times out.
    send_byte(8'h12, 1'b1, 1'b0);
    send_byte(8'h34, 1'b1, 1'b0);
    idle(12);
    model_timeout();
    check_flags("t5_flags");
    send_word(32'h12345678, 2);
    clear_flags();

`ifdef UART_WORD_RX_PARITY_EN
    send_byte(8'h01, 1'b1, 1'b1);
    idle(1);
    check_flags("t6_parity_flag");
    send_word(32'hCAFE0001, 2);
    clear_flags();
`else
    send_word(32'h0BADF00D, 2);
    chk("t6_no_parity_flag", {31'd0, error_flags[2]}, 32'd0);
`endif

    // Randomised bytes with gaps, bad stop bits and glitches.
    for (int n = 0; n < 48; n++) begin
      logic [7:0] b;
      bit bad;
      bit pf;
      int gap;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 9) == 0);
`ifdef UART_WORD_RX_PARITY_EN
      pf  = ($urandom_range(0, 9) == 0);
`else
      pf  = 1'b0;
`endif
      send_byte(b, !bad, pf);
      gap = bad ? 1 + int'($urandom_range(0, 2)) : int'($urandom_range(0, 3));
      idle(gap);
      if ($urandom_range(0, 7) == 0) begin
        idle(1);
        uart_rx = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        idle(2);
      end
    end
    idle(3);
    check_flags("rand_flags");
    clear_flags();

    // Reset in the middle of a byte while a partial word is held.
    send_byte(8'h77, 1'b1, 1'b0);
    send_byte(8'h66, 1'b0, 1'b0);
    idle(1);
    send_byte(8'h99, 1'b1, 1'b0);
    uart_rx = 1'b0;
    repeat (CPB + 5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_data_out", data_out, 32'd0);
    chk("midrst_valid", {31'd0, data_valid}, 32'd0);
    chk("midrst_flags", {28'd0, error_flags}, 32'd0);
    part.delete();
    mflags = 4'd0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    send_word(32'hC0FFEE42, 3);
    check_flags("post_rst_flags");

    idle(4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
